// File: rtl/exu_writeback.sv
// Register-file writeback arbiter: merges single-cycle ALU/BJP/CSR results with one outstanding MULDIV/MEM result.
// Optional build macro WB_SKID_BUF_EN: scoreboard stall plus skid buffer and DRAIN state; undefined gives a blocking stall.
module exu_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    input  logic        long_start_i,
    input  logic        long_we_i,
    input  logic [4:0]  long_waddr_i,
    input  logic        long_valid_i,
    input  logic [31:0] long_wdata_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_long_i,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        hold_o,
    output logic        busy_o,
    output logic        spurious_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_we_q, pend_we_d;
    logic [4:0]  pend_rd_q, pend_rd_d;

`ifdef WB_SKID_BUF_EN
    logic        skid_vld_q, skid_vld_d;
    logic [4:0]  skid_addr_q, skid_addr_d;
    logic [31:0] skid_data_q, skid_data_d;
`endif

    logic        long_fire;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hold_raw;

    assign long_fire = (state_q == WAIT) && long_valid_i;

    // Next-state and pending/skid bookkeeping
    always_comb begin
        state_d   = state_q;
        pend_we_d = pend_we_q;
        pend_rd_d = pend_rd_q;
`ifdef WB_SKID_BUF_EN
        skid_vld_d  = skid_vld_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (long_start_i) begin
                    state_d   = WAIT;
                    pend_we_d = long_we_i;
                    pend_rd_d = long_waddr_i;
                end
            end
            WAIT: begin
                if (long_valid_i) begin
                    pend_we_d = 1'b0;
                    state_d   = IDLE;
`ifdef WB_SKID_BUF_EN
                    // ALU owns the write port this cycle; park the long result
                    if (alu_we_i) begin
                        state_d     = DRAIN;
                        skid_vld_d  = pend_we_q;
                        skid_addr_d = pend_rd_q;
                        skid_data_d = long_wdata_i;
                    end
`endif
                end
            end
`ifdef WB_SKID_BUF_EN
            DRAIN: begin
                state_d    = IDLE;
                skid_vld_d = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_we_q <= 1'b0;
            pend_rd_q <= '0;
`ifdef WB_SKID_BUF_EN
            skid_vld_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pend_we_q <= pend_we_d;
            pend_rd_q <= pend_rd_d;
`ifdef WB_SKID_BUF_EN
            skid_vld_q  <= skid_vld_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
`endif
        end
    end

    // Write-port arbitration: skid drain, then ALU, then long result
    always_comb begin
        wr_en   = alu_we_i;
        wr_addr = alu_waddr_i;
        wr_data = alu_wdata_i;
        if (!alu_we_i && long_fire) begin
            wr_en   = pend_we_q;
            wr_addr = pend_rd_q;
            wr_data = long_wdata_i;
        end
`ifdef WB_SKID_BUF_EN
        if (state_q == DRAIN) begin
            wr_en   = skid_vld_q;
            wr_addr = skid_addr_q;
            wr_data = skid_data_q;
        end
`endif
    end

    always_comb begin
        hold_raw = 1'b0;
        case (state_q)
            WAIT: begin
`ifdef WB_SKID_BUF_EN
                hold_raw = ((pend_rd_q != 5'd0) &&
                            ((pend_rd_q == dec_rs1_i) ||
                             (pend_rd_q == dec_rs2_i) ||
                             (pend_rd_q == dec_rd_i))) || dec_long_i;
`else
                hold_raw = 1'b1;
`endif
            end
            DRAIN:   hold_raw = 1'b1;
            default: hold_raw = 1'b0;
        endcase
    end

`ifndef WB_SKID_BUF_EN
    logic unused_dec;
    assign unused_dec = ^{dec_rs1_i, dec_rs2_i, dec_rd_i, dec_long_i};
`endif

    // Outputs are forced low for the whole reset window, including pass-through paths
    assign reg_we_o    = rst_n && wr_en && (wr_addr != 5'd0);
    assign reg_waddr_o = rst_n ? wr_addr : '0;
    assign reg_wdata_o = rst_n ? wr_data : '0;
    assign hold_o      = rst_n && hold_raw;
    assign busy_o      = rst_n && (((state_q == WAIT) && !long_valid_i) || (state_q == DRAIN));
    assign spurious_o  = rst_n && long_valid_i && (state_q != WAIT);

endmodule

// File: tb/tb_exu_writeback.sv
// Scoreboard bench for exu_writeback: driver queues per-cycle expectations, a negedge monitor compares.
module tb_exu_writeback;

`ifdef WB_SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we_i;
    logic [4:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        long_start_i;
    logic        long_we_i;
    logic [4:0]  long_waddr_i;
    logic        long_valid_i;
    logic [31:0] long_wdata_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  dec_rd_i;
    logic        dec_long_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        hold_o;
    logic        busy_o;
    logic        spurious_o;

    exu_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .long_start_i(long_start_i), .long_we_i(long_we_i), .long_waddr_i(long_waddr_i),
        .long_valid_i(long_valid_i), .long_wdata_i(long_wdata_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i), .dec_long_i(dec_long_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .hold_o(hold_o), .busy_o(busy_o), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hold;
        logic        busy;
        logic        spur;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // hold expected in a WAIT cycle when the decode fields do not hit pend_rd
    localparam bit WH = SKID ? 1'b0 : 1'b1;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (reg_we_o !== e.we || hold_o !== e.hold || busy_o !== e.busy ||
                spurious_o !== e.spur ||
                (e.we && (reg_waddr_o !== e.wa || reg_wdata_o !== e.wd))) begin
                errors++;
                $display("FAIL %s: got we=%b wa=%0d wd=%h hold=%b busy=%b spur=%b, expected we=%b wa=%0d wd=%h hold=%b busy=%b spur=%b",
                         e.name, reg_we_o, reg_waddr_o, reg_wdata_o, hold_o, busy_o, spurious_o,
                         e.we, e.wa, e.wd, e.hold, e.busy, e.spur);
            end
        end
    end

    task automatic idle_inputs();
        alu_we_i     = 1'b0;
        alu_waddr_i  = '0;
        alu_wdata_i  = '0;
        long_start_i = 1'b0;
        long_we_i    = 1'b0;
        long_waddr_i = '0;
        long_valid_i = 1'b0;
        long_wdata_i = '0;
        dec_rs1_i    = '0;
        dec_rs2_i    = '0;
        dec_rd_i     = '0;
        dec_long_i   = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic ewe, input logic [4:0] ewa,
                       input logic [31:0] ewd, input logic eh, input logic eb, input logic es);
        exp_t e;
        e.name = nm; e.we = ewe; e.wa = ewa; e.wd = ewd;
        e.hold = eh; e.busy = eb; e.spur = es;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        alu_we_i = 1'b1; alu_waddr_i = a; alu_wdata_i = d;
    endtask

    task automatic lstart(input logic we, input logic [4:0] rd);
        long_start_i = 1'b1; long_we_i = we; long_waddr_i = rd;
    endtask

    task automatic lvalid(input logic [31:0] d);
        long_valid_i = 1'b1; long_wdata_i = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs low even with an ALU write and a completion present
        alu(5'd5, 32'h1234); lvalid(32'h1);
        cyc("rst_outputs_low", 0, 0, 0, 0, 0, 0);
        alu(5'd5, 32'h1234);
        cyc("rst_outputs_low2", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Single-cycle pass-through and x0 suppression
        alu(5'd5, 32'h1234);
        cyc("alu_x5", 1, 5, 32'h1234, 0, 0, 0);
        alu(5'd0, 32'hFFFF);
        cyc("alu_x0_suppressed", 0, 0, 0, 0, 0, 0);
        alu(5'd31, 32'hFFFF_FFFF);
        cyc("alu_x31", 1, 31, 32'hFFFF_FFFF, 0, 0, 0);

        // Long op rd=7, completes three cycles after issue
        lstart(1'b1, 5'd7);
        cyc("long7_issue", 0, 0, 0, 0, 0, 0);
        cyc("long7_wait1", 0, 0, 0, WH, 1, 0);
        lstart(1'b1, 5'd9);
        cyc("long7_wait2_start_ignored", 0, 0, 0, WH, 1, 0);
        lvalid(32'hDEAD_BEEF);
        cyc("long7_complete", 1, 7, 32'hDEAD_BEEF, WH, 0, 0);
        lvalid(32'h77);
        cyc("long7_back_idle_spurious", 0, 0, 0, 0, 0, 1);
        cyc("idle_quiet", 0, 0, 0, 0, 0, 0);

        // ALU write during WAIT passes through; long result follows alone
        lstart(1'b1, 5'd12);
        cyc("long12_issue", 0, 0, 0, 0, 0, 0);
        alu(5'd3, 32'hCAFE);
        cyc("alu_during_wait", 1, 3, 32'hCAFE, WH, 1, 0);
        lvalid(32'h99);
        cyc("long12_complete", 1, 12, 32'h99, WH, 0, 0);

        // Destination x0 and pend_we=0 both produce no write
        lstart(1'b1, 5'd0);
        cyc("long_rd0_issue", 0, 0, 0, 0, 0, 0);
        cyc("long_rd0_wait", 0, 0, 0, WH, 1, 0);
        lvalid(32'h1111);
        cyc("long_rd0_complete_nowrite", 0, 0, 0, WH, 0, 0);
        lstart(1'b0, 5'd8);
        cyc("long_nowe_issue", 0, 0, 0, 0, 0, 0);
        lvalid(32'h2222);
        cyc("long_nowe_complete_nowrite", 0, 0, 0, WH, 0, 0);
        lvalid(32'h3333);
        cyc("idle_spurious", 0, 0, 0, 0, 0, 1);
        cyc("spurious_one_cycle", 0, 0, 0, 0, 0, 0);

        // Reset in WAIT abandons the op
        lstart(1'b1, 5'd10);
        cyc("long10_issue", 0, 0, 0, 0, 0, 0);
        cyc("long10_wait", 0, 0, 0, WH, 1, 0);
        rst_n = 1'b0;
        alu(5'd3, 32'h5);
        cyc("midop_reset_low", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        lvalid(32'h55);
        cyc("after_reset_spurious", 0, 0, 0, 0, 0, 1);

`ifdef WB_SKID_BUF_EN
        // Scoreboard stall, then collision through the skid buffer
        lstart(1'b1, 5'd7);
        cyc("skid_issue", 0, 0, 0, 0, 0, 0);
        dec_rs1_i = 5'd7;
        cyc("sb_rs1_hit", 0, 0, 0, 1, 1, 0);
        dec_rs1_i = 5'd3; dec_rd_i = 5'd4;
        cyc("sb_miss", 0, 0, 0, 0, 1, 0);
        dec_rs2_i = 5'd7;
        cyc("sb_rs2_hit", 0, 0, 0, 1, 1, 0);
        dec_rd_i = 5'd7;
        cyc("sb_rd_hit", 0, 0, 0, 1, 1, 0);
        dec_long_i = 1'b1;
        cyc("sb_dec_long", 0, 0, 0, 1, 1, 0);
        lvalid(32'hA5); alu(5'd4, 32'h11);
        cyc("collide_alu_wins", 1, 4, 32'h11, 0, 0, 0);
        cyc("drain_skid_x7", 1, 7, 32'hA5, 1, 1, 0);
        lvalid(32'h66);
        cyc("after_drain_idle", 0, 0, 0, 0, 0, 1);
        lstart(1'b1, 5'd0);
        cyc("sb_rd0_issue", 0, 0, 0, 0, 0, 0);
        dec_rs1_i = 5'd0;
        cyc("sb_rd0_nohold", 0, 0, 0, 0, 1, 0);
        lvalid(32'h1); alu(5'd2, 32'h2);
        cyc("collide_rd0", 1, 2, 32'h2, 0, 0, 0);
        cyc("drain_rd0_nowrite", 0, 0, 0, 1, 1, 0);
        cyc("after_drain2", 0, 0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
